// File: rtl/exec_ctrl.sv
// Execution sequencer: waits out ROM/RAM read latency, then issues one commit strobe per instruction.
// Optional PC breakpoint halt when BREAKPOINT_EN is defined; bp_addr is ignored otherwise.
module exec_ctrl #(
  parameter int FETCH_LAT = 1,
  parameter int MEM_LAT   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_pulse,
  input  logic             run_toggle,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             mem_ren,
  input  logic [31:0]      bp_addr,
  output logic             commit,
  output logic             running,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [3:0]  FETCH_LD = 4'(FETCH_LAT - 1);
  localparam logic [3:0]  MEM_LD   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
  localparam logic [1:0]  CAUSE_RESET = 2'd0;
  localparam logic [1:0]  CAUSE_USER  = 2'd1;
  localparam logic [1:0]  CAUSE_EBRK  = 2'd2;
  localparam logic [1:0]  CAUSE_BP    = 2'd3;

  typedef enum logic [1:0] {
    S_HALT   = 2'd0,
    S_FETCH  = 2'd1,
    S_MEM    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_wait;
  logic             r_commit;
  logic             r_running;
  logic             r_halted;
  logic             r_stop_req;
  logic [1:0]       r_halt_cause;
  logic [CNT_W-1:0] r_count;

  logic w_fetch_done;
  logic w_to_mem;
  logic w_to_commit;
  logic w_ebreak_hit;
  logic w_bp_hit;

  assign w_fetch_done = (r_state == S_FETCH) && (r_wait == 4'd0);
  assign w_to_mem     = w_fetch_done && mem_ren && (MEM_LAT > 0);
  assign w_to_commit  = (w_fetch_done && !w_to_mem) ||
                        ((r_state == S_MEM) && (r_wait == 4'd0));
  assign w_ebreak_hit = r_running && (instr == EBREAK);

`ifdef BREAKPOINT_EN
  logic r_skip_bp;
  assign w_bp_hit = r_running && !r_skip_bp && (pc == bp_addr);

  // The first instruction after a run start is exempt so a breakpoint halt can be resumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip_bp <= 1'b0;
    end else if ((r_state == S_HALT) && run_toggle) begin
      r_skip_bp <= 1'b1;
    end else if (w_to_commit && !w_ebreak_hit && !w_bp_hit) begin
      r_skip_bp <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_bp_hit = 1'b0;
  assign w_unused = &{1'b0, pc, bp_addr};
`endif

  // The commit decision is taken on the edge entering COMMIT so the strobe itself is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_HALT;
      r_wait       <= 4'd0;
      r_commit     <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b1;
      r_stop_req   <= 1'b0;
      r_halt_cause <= CAUSE_RESET;
      r_count      <= '0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        S_HALT: begin
          if (run_toggle) begin
            r_running  <= 1'b1;
            r_stop_req <= 1'b0;
            r_halted   <= 1'b0;
            r_wait     <= FETCH_LD;
            r_state    <= S_FETCH;
          end else if (step_pulse) begin
            r_running  <= 1'b0;
            r_stop_req <= 1'b0;
            r_halted   <= 1'b0;
            r_wait     <= FETCH_LD;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_running && run_toggle) r_stop_req <= 1'b1;
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else if (w_to_mem) begin
            r_wait  <= MEM_LD;
            r_state <= S_MEM;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_MEM: begin
          if (r_running && run_toggle) r_stop_req <= 1'b1;
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (r_commit && r_running && !r_stop_req) begin
            r_stop_req <= run_toggle;
            r_wait     <= FETCH_LD;
            r_state    <= S_FETCH;
          end else begin
            r_stop_req <= 1'b0;
            r_halted   <= 1'b1;
            r_state    <= S_HALT;
            if (r_commit) begin
              r_running    <= 1'b0;
              r_halt_cause <= CAUSE_USER;
            end
          end
        end
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase

      if (w_to_commit) begin
        if (w_ebreak_hit) begin
          r_running    <= 1'b0;
          r_halt_cause <= CAUSE_EBRK;
        end else if (w_bp_hit) begin
          r_running    <= 1'b0;
          r_halt_cause <= CAUSE_BP;
        end else begin
          r_commit <= 1'b1;
          r_count  <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign commit      = r_commit;
  assign running     = r_running;
  assign halted      = r_halted;
  assign halt_cause  = r_halt_cause;
  assign instr_count = r_count;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: models PC32 advance on commit and a small ROM image.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_pulse = 1'b0;
  logic        run_toggle = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        mem_ren = 1'b0;
  logic [31:0] bp_addr = 32'hFFFF_FFFF;
  logic        commit;
  logic        running;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_b2b = 0;
  int clog[$];
  logic prev_commit = 1'b0;
  logic [31:0] rom [0:15];

  exec_ctrl #(.FETCH_LAT(1), .MEM_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .step_pulse(step_pulse), .run_toggle(run_toggle),
    .pc(pc), .instr(instr), .mem_ren(mem_ren), .bp_addr(bp_addr),
    .commit(commit), .running(running), .halted(halted),
    .halt_cause(halt_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0;
    else if (commit) pc <= pc + 32'd4;
  end

  assign instr = rom[pc[5:2]];

  // Commit in the period after edge e is recorded as cycle e+1.
  always @(negedge clk) begin
    if (commit) clog.push_back(cyc + 1);
    if (commit && prev_commit) n_b2b++;
    prev_commit = commit;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clog.delete();
  endtask

  // Pulses a strobe for one edge; returns the index of the sampling edge.
  task automatic pulse(input logic do_step, input logic do_run, output int k);
    @(negedge clk);
    k = cyc + 1;
    step_pulse = do_step;
    run_toggle = do_run;
    @(posedge clk);
    #1;
    step_pulse = 1'b0;
    run_toggle = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    @(negedge clk);
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int k;
    int n;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0010_0093;
    rom[5] = 32'h0010_0073;

    do_reset();
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_count", instr_count, 32'd0);

    // Single step, non-load
    pulse(1'b1, 1'b0, k);
    wait_halted("step_halt");
    check("step_ncommit", 32'(clog.size()), 32'd1);
    if (clog.size() > 0) check("step_lat", 32'(clog[0]), 32'(k + 2));
    check("step_count", instr_count, 32'd1);
    check("step_cause", 32'(halt_cause), 32'd1);
    check("step_pc", pc, 32'h4);

    // Single step, load
    do_reset();
    mem_ren = 1'b1;
    pulse(1'b1, 1'b0, k);
    wait_halted("load_halt");
    mem_ren = 1'b0;
    check("load_ncommit", 32'(clog.size()), 32'd1);
    if (clog.size() > 0) check("load_lat", 32'(clog[0]), 32'(k + 3));
    check("load_count", instr_count, 32'd1);

    // Free-run to EBREAK at 0x14
    do_reset();
    pulse(1'b0, 1'b1, k);
    check("run_running", 32'(running), 32'd1);
    check("run_halted", 32'(halted), 32'd0);
    wait_halted("ebrk_halt");
    check("ebrk_ncommit", 32'(clog.size()), 32'd5);
    for (int i = 0; i < 5 && i < clog.size(); i++)
      check($sformatf("ebrk_c%0d", i), 32'(clog[i]), 32'(k + 2 + 2 * i));
    check("ebrk_cause", 32'(halt_cause), 32'd2);
    check("ebrk_running", 32'(running), 32'd0);
    check("ebrk_count", instr_count, 32'd5);
    check("ebrk_pc", pc, 32'h14);
    pulse(1'b1, 1'b0, k);
    wait_halted("ebrk_step_halt");
    check("ebrk_step_count", instr_count, 32'd6);
    check("ebrk_step_cause", 32'(halt_cause), 32'd1);
    check("ebrk_step_pc", pc, 32'h18);

    // Stop request in FETCH with a simultaneous ignored step
    do_reset();
    pulse(1'b0, 1'b1, k);
    pulse(1'b1, 1'b1, n);
    wait_halted("stop_halt");
    repeat (10) @(negedge clk);
    check("stop_count", instr_count, 32'd1);
    check("stop_cause", 32'(halt_cause), 32'd1);
    check("stop_running", 32'(running), 32'd0);
    if (clog.size() > 0) check("stop_lat", 32'(clog[0]), 32'(k + 2));

`ifdef BREAKPOINT_EN
    do_reset();
    bp_addr = 32'h8;
    pulse(1'b0, 1'b1, k);
    wait_halted("bp_halt");
    check("bp_cause", 32'(halt_cause), 32'd3);
    check("bp_count", instr_count, 32'd2);
    check("bp_pc", pc, 32'h8);
    check("bp_running", 32'(running), 32'd0);
    pulse(1'b0, 1'b1, k);
    wait_halted("bp_resume_halt");
    check("bp_resume_cause", 32'(halt_cause), 32'd2);
    check("bp_resume_count", instr_count, 32'd5);
    bp_addr = 32'hFFFF_FFFF;
`else
    do_reset();
    bp_addr = 32'h8;
    pulse(1'b0, 1'b1, k);
    wait_halted("nobp_halt");
    check("nobp_cause", 32'(halt_cause), 32'd2);
    check("nobp_count", instr_count, 32'd5);
    bp_addr = 32'hFFFF_FFFF;
`endif

    // Async reset during FETCH of the third instruction
    do_reset();
    pulse(1'b0, 1'b1, k);
    n = 0;
    while (!(instr_count == 32'd2 && !commit) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arst_reach", 32'(n < 50), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_commit", 32'(commit), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_halted", 32'(halted), 32'd1);
    check("arst_cause", 32'(halt_cause), 32'd0);
    check("arst_count", instr_count, 32'd0);
    clog.delete();
    repeat (3) @(negedge clk);
    check("arst_nocommit", 32'(clog.size()), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    check("no_back2back", 32'(n_b2b), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Execution sequencer for the single-cycle RV32 core. It replaces the raw button strobe that gates PC, register-file and RAM writes. It waits out synchronous ROM/RAM read latency, then issues exactly one commit strobe per instruction. Supports single-step, free-run, stop-on-EBREAK and an optional PC breakpoint. Sits between the button debouncer and the PC32/RegFile32/RAM write enables.

Parameters:
FETCH_LAT, 1, cycles from PC update to valid instr from ROM; legal range 1..15
MEM_LAT, 1, extra cycles for a load's RAM read data to be valid; legal range 0..15 (0 = no MEM state)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
step_pulse  in  1  one-cycle strobe (debounced button edge); request one instruction
run_toggle  in  1  one-cycle strobe; start free-run when halted, request stop when running
pc  in  32  current PC from PC32
instr  in  32  current instruction from ROM
mem_ren  in  1  decoder load indication for current instr
bp_addr  in  32  breakpoint PC (used only with BREAKPOINT_EN)
commit  out  1  one-cycle write enable; ANDed into pc_wen, reg_wen, mem_wen
running  out  1  1 while in free-run mode
halted  out  1  1 while in state HALT
halt_cause  out  2  0 reset, 1 user stop/step done, 2 EBREAK, 3 breakpoint
instr_count  out  CNT_W  retired instructions (commits)

Behaviour:
- Reset (rst=0, async): state HALT. commit=0, running=0, halted=1, halt_cause=0, instr_count=0, stop_req=0, skip_bp=0, wait counter=0.
- States: HALT, FETCH, MEM, COMMIT. All are registered and update on the rising edge of clk.
- HALT:
  - run_toggle=1 -> running=1, skip_bp=1, go FETCH.
  - Otherwise step_pulse=1 -> go FETCH with running=0.
  - Both strobes asserted in the same cycle -> run_toggle wins.
  - halted=0 in every state other than HALT.
- FETCH:
  - Stays exactly FETCH_LAT cycles (counter loaded on entry).
  - On the last cycle, if mem_ren=1 and MEM_LAT>0 -> MEM; else -> COMMIT.
- MEM: stays exactly MEM_LAT cycles, then -> COMMIT.
- COMMIT (one cycle), evaluated in this priority:
  1. running=1 and instr==32'h0010_0073 (EBREAK): commit=0, running=0, halt_cause=2 -> HALT. PC does not advance.
  2. BREAKPOINT_EN, running=1, skip_bp=0, pc==bp_addr: commit=0, running=0, halt_cause=3 -> HALT.
  3. Otherwise: commit=1, instr_count+=1 (wraps modulo 2^CNT_W), skip_bp cleared. Then:
     - running=1 and stop_req=0 -> FETCH.
     - Otherwise running=0, stop_req=0, halt_cause=1 -> HALT.
- commit is a registered output, high only in the COMMIT cycle of case 3. It is never high for two consecutive cycles.
- Latency, non-load: step_pulse sampled at edge k -> commit high during cycle k+1+FETCH_LAT.
- Latency, load: same as non-load plus MEM_LAT.
- While running:
  - run_toggle sets stop_req. The in-flight instruction always completes; it is never aborted.
  - step_pulse is ignored.
- In FETCH/MEM during a single step: both strobes are ignored.
- Single-step over EBREAK or a breakpoint PC commits normally (case 3), so the user can step past them.
- Resume from a breakpoint: skip_bp suppresses the compare for the first instruction only.
- Async reset mid-instruction: FSM returns to HALT immediately, and commit drops in the same cycle as rst assertion.

Optional Feature:
BREAKPOINT_EN. Defined: bp_addr compared against pc in COMMIT during free-run (priority 2 above); halt_cause=3 reachable. Undefined: no comparator, no skip_bp register; bp_addr is unused; halt_cause never equals 3.

Test Plan:
- Reset, then one step_pulse, defaults, instr=ADDI (mem_ren=0) -> commit high exactly in cycle k+2, instr_count=1, halted=1, halt_cause=1.
- step_pulse with mem_ren=1, MEM_LAT=1 -> commit in cycle k+3; MEM visited once; instr_count=1.
- run_toggle, 5 ADDIs, then EBREAK at pc=0x14 -> 5 commits spaced 2 cycles apart; no commit for EBREAK; halt_cause=2, running=0, instr_count=5; a following step_pulse commits the EBREAK (count=6).
- Running, run_toggle asserted in the FETCH cycle -> the current instruction still commits, then HALT with halt_cause=1; a simultaneous step_pulse while running is ignored.
- BREAKPOINT_EN, bp_addr=0x8, run from pc=0 -> halt at pc=0x8 with no commit, halt_cause=3, count=2; run_toggle again -> 0x8 commits, execution continues.
- rst driven low during FETCH of the 3rd instruction -> all outputs at reset values asynchronously, count=0, no commit.
